// File: rtl/instruction_decode.sv
// Decode stage between fetch and execute: collects opcode (+ optional immediate)
// over a DOR/ack handshake, presents registered decode fields, counts retirements.
module instruction_decode #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter bit          HALT_STICKY = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   DIR,
  input  logic [7:0]             data_in,
  output logic                   ack_prev,
  output logic                   DOR,
  input  logic                   ack_from_next,
  output logic [3:0]             alu_op,
  output logic [1:0]             rd,
  output logic [1:0]             rs,
  output logic [7:0]             imm,
  output logic                   has_imm,
  output logic                   is_mem,
  output logic                   is_branch,
  output logic                   illegal,
  output logic                   halt,
  output logic [COUNT_WIDTH-1:0] insn_count
);

  typedef enum logic [2:0] {
    IDLE,
    ACK_OP,
    WAIT_IMM,
    ACK_IMM,
    OUT,
    HALTED
  } state_t;

  state_t     state;
  logic [7:0] opcode_q;
  logic [7:0] imm_q;

  logic [3:0] cls;
  logic       dec_has_imm;
  logic       dec_mem;
  logic       dec_branch;
  logic       dec_illegal;
  logic       dec_halt;
  logic       emit;

  always_comb begin
    cls         = opcode_q[7:4];
    dec_has_imm = (cls == 4'h1) || (cls == 4'h8) || (cls == 4'h9) ||
                  (cls == 4'hA) || (cls == 4'hB);
    dec_mem     = (cls == 4'h8) || (cls == 4'h9);
    dec_branch  = (cls == 4'hA) || (cls == 4'hB);
    dec_illegal = (cls == 4'hC) || (cls == 4'hD) || (cls == 4'hE);
    dec_halt    = (cls == 4'hF);
    // Fields are loaded on the cycle that raises DOR and then held untouched.
    emit        = ((state == ACK_OP) && !dec_has_imm) || (state == ACK_IMM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      opcode_q   <= '0;
      imm_q      <= '0;
      ack_prev   <= 1'b0;
      DOR        <= 1'b0;
      alu_op     <= '0;
      rd         <= '0;
      rs         <= '0;
      imm        <= '0;
      has_imm    <= 1'b0;
      is_mem     <= 1'b0;
      is_branch  <= 1'b0;
      illegal    <= 1'b0;
      halt       <= 1'b0;
      insn_count <= '0;
    end else begin
      ack_prev <= 1'b0;
      case (state)
        IDLE: begin
          if (DIR) begin
            opcode_q <= data_in;
            ack_prev <= 1'b1;
            state    <= ACK_OP;
          end
        end
        ACK_OP: begin
          if (dec_has_imm) begin
            state <= WAIT_IMM;
          end else begin
            DOR   <= 1'b1;
            state <= OUT;
          end
        end
        WAIT_IMM: begin
          if (DIR) begin
            imm_q    <= data_in;
            ack_prev <= 1'b1;
            state    <= ACK_IMM;
          end
        end
        ACK_IMM: begin
          DOR   <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          if (ack_from_next) begin
            DOR        <= 1'b0;
            insn_count <= insn_count + COUNT_WIDTH'(1);
            state      <= (dec_halt && HALT_STICKY) ? HALTED : IDLE;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase

      if (emit) begin
        alu_op    <= opcode_q[7:4];
        rd        <= opcode_q[3:2];
        rs        <= opcode_q[1:0];
        imm       <= dec_has_imm ? imm_q : '0;
        has_imm   <= dec_has_imm;
        is_mem    <= dec_mem;
        is_branch <= dec_branch;
        illegal   <= dec_illegal;
        halt      <= dec_halt;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode; inputs driven and
// outputs sampled on the falling edge.
module tb_instruction_decode;

  logic       clk;
  logic       reset;
  logic       DIR;
  logic [7:0] data_in;
  logic       ack_prev;
  logic       DOR;
  logic       ack_from_next;
  logic [3:0] alu_op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] imm;
  logic       has_imm, is_mem, is_branch, illegal, halt;
  logic [7:0] insn_count;

  int checks = 0;
  int errors = 0;

  // {alu_op, rd, rs, imm, has_imm, is_mem, is_branch, illegal, halt}
  logic [20:0] fields;
  assign fields = {alu_op, rd, rs, imm, has_imm, is_mem, is_branch, illegal, halt};

  instruction_decode #(.COUNT_WIDTH(8), .HALT_STICKY(1'b1)) dut (
    .clk(clk), .reset(reset), .DIR(DIR), .data_in(data_in),
    .ack_prev(ack_prev), .DOR(DOR), .ack_from_next(ack_from_next),
    .alu_op(alu_op), .rd(rd), .rs(rs), .imm(imm),
    .has_imm(has_imm), .is_mem(is_mem), .is_branch(is_branch),
    .illegal(illegal), .halt(halt), .insn_count(insn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    DIR = 1'b1;
    data_in = b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_prev) begin
        ok = 1'b1;
        break;
      end
    end
    DIR = 1'b0;
  endtask

  task automatic wait_dor(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (DOR) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic exec_ack();
    ack_from_next = 1'b1;
    @(negedge clk);
    ack_from_next = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    DIR = 1'b1;
    data_in = 8'h2B;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({ack_prev, DOR, fields, insn_count} !== 31'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got ack=%b dor=%b fields=%h cnt=%h, want all 0",
                 i, ack_prev, DOR, fields, insn_count);
      end
    end
    DIR = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    DIR = 1'b1;
    data_in = 8'h2B;
    @(negedge clk);
    checks++;
    if ({ack_prev, DOR} !== 2'b10) begin
      errors++;
      $display("FAIL single_ack: got ack=%b dor=%b, want ack=1 dor=0", ack_prev, DOR);
    end
    DIR = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack_prev, DOR} !== 2'b01) begin
      errors++;
      $display("FAIL single_dor_latency: got ack=%b dor=%b, want ack=0 dor=1", ack_prev, DOR);
    end
    checks++;
    if (fields !== {4'h2, 2'd2, 2'd3, 8'h00, 5'b00000}) begin
      errors++;
      $display("FAIL single_fields: got %h want %h", fields, {4'h2, 2'd2, 2'd3, 8'h00, 5'b00000});
    end
    // ack_from_next while DOR=0 is ignored: verified implicitly by count later
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (DOR !== 1'b1 || insn_count !== 8'd0) begin
      errors++;
      $display("FAIL single_hold: got dor=%b cnt=%0d, want dor=1 cnt=0", DOR, insn_count);
    end
    exec_ack();
    checks++;
    if (DOR !== 1'b0 || insn_count !== 8'd1) begin
      errors++;
      $display("FAIL single_retire: got dor=%b cnt=%0d, want dor=0 cnt=1", DOR, insn_count);
    end
  endtask

  task automatic test_ack_while_idle();
    ack_from_next = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack_from_next = 1'b0;
    checks++;
    if (insn_count !== 8'd1 || DOR !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: got cnt=%0d dor=%b, want cnt=1 dor=0", insn_count, DOR);
    end
  endtask

  task automatic test_two_byte();
    int acks = 0;
    DIR = 1'b1;
    data_in = 8'h84;
    @(negedge clk);
    if (ack_prev) acks++;
    @(negedge clk);                   // DIR still high: ignore cycle
    if (ack_prev) acks++;
    data_in = 8'h5A;
    @(negedge clk);
    if (ack_prev) acks++;
    @(negedge clk);                   // DIR still high: ignore cycle
    if (ack_prev) acks++;
    checks++;
    if (DOR !== 1'b1) begin
      errors++;
      $display("FAIL two_dor_latency: got dor=%b want 1", DOR);
    end
    @(negedge clk);                   // DIR high during OUT must not be acked
    if (ack_prev) acks++;
    DIR = 1'b0;
    checks++;
    if (acks != 2) begin
      errors++;
      $display("FAIL two_ack_pulses: got %0d want 2", acks);
    end
    checks++;
    if (fields !== {4'h8, 2'd1, 2'd0, 8'h5A, 5'b11000}) begin
      errors++;
      $display("FAIL two_fields: got %h want %h", fields, {4'h8, 2'd1, 2'd0, 8'h5A, 5'b11000});
    end
    exec_ack();
    checks++;
    if (DOR !== 1'b0 || insn_count !== 8'd2) begin
      errors++;
      $display("FAIL two_retire: got dor=%b cnt=%0d, want dor=0 cnt=2", DOR, insn_count);
    end
  endtask

  task automatic test_illegal();
    bit ok1, ok2;
    issue_byte(8'hC0, ok1);
    wait_dor(ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL illegal_handshake: got ack_ok=%b dor_ok=%b want 1 1", ok1, ok2);
    end
    checks++;
    if (fields !== {4'hC, 2'd0, 2'd0, 8'h00, 5'b00010}) begin
      errors++;
      $display("FAIL illegal_fields: got %h want %h", fields, {4'hC, 2'd0, 2'd0, 8'h00, 5'b00010});
    end
    exec_ack();
  endtask

  task automatic test_halt();
    bit ok1, ok2;
    int acks = 0;
    int dors = 0;
    issue_byte(8'hF0, ok1);
    wait_dor(ok2);
    checks++;
    if (!(ok1 && ok2) || fields !== {4'hF, 2'd0, 2'd0, 8'h00, 5'b00001}) begin
      errors++;
      $display("FAIL halt_emit: got ok=%b%b fields=%h want ok=11 fields=%h",
               ok1, ok2, fields, {4'hF, 2'd0, 2'd0, 8'h00, 5'b00001});
    end
    exec_ack();
    checks++;
    if (insn_count !== 8'd4) begin
      errors++;
      $display("FAIL halt_count: got %0d want 4", insn_count);
    end
    DIR = 1'b1;
    data_in = 8'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_prev) acks++;
      if (DOR) dors++;
    end
    DIR = 1'b0;
    checks++;
    if (acks != 0 || dors != 0) begin
      errors++;
      $display("FAIL halted_sticky: got acks=%0d dor_cycles=%0d want 0 0", acks, dors);
    end
    pulse_reset();
    checks++;
    if (insn_count !== 8'd0 || fields !== 21'd0) begin
      errors++;
      $display("FAIL halt_reset: got cnt=%0d fields=%h want 0 0", insn_count, fields);
    end
    issue_byte(8'h10, ok1);
    issue_byte(8'h07, ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL ldi_acks: got %b%b want 11", ok1, ok2);
    end
    wait_dor(ok1);
    checks++;
    if (!ok1 || fields !== {4'h1, 2'd0, 2'd0, 8'h07, 5'b10000}) begin
      errors++;
      $display("FAIL ldi_fields: got dor_ok=%b fields=%h want 1 %h",
               ok1, fields, {4'h1, 2'd0, 2'd0, 8'h07, 5'b10000});
    end
    exec_ack();
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    pulse_reset();
    issue_byte(8'hA0, ok1);
    @(negedge clk);                   // now waiting for the immediate
    pulse_reset();
    checks++;
    if (!ok1 || DOR !== 1'b0 || insn_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got ack_ok=%b dor=%b cnt=%0d want 1 0 0", ok1, DOR, insn_count);
    end
    issue_byte(8'h2B, ok1);
    wait_dor(ok2);
    checks++;
    if (!(ok1 && ok2) || fields !== {4'h2, 2'd2, 2'd3, 8'h00, 5'b00000}) begin
      errors++;
      $display("FAIL mid_reset_opcode: got ok=%b%b fields=%h want 11 %h",
               ok1, ok2, fields, {4'h2, 2'd2, 2'd3, 8'h00, 5'b00000});
    end
    exec_ack();
    checks++;
    if (insn_count !== 8'd1) begin
      errors++;
      $display("FAIL mid_reset_count: got %0d want 1", insn_count);
    end
  endtask

  task automatic test_wrap_and_stall();
    bit ok1, ok2;
    int bad = 0;
    pulse_reset();
    issue_byte(8'h07, ok1);
    wait_dor(ok2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (DOR !== 1'b1 || fields !== {4'h0, 2'd1, 2'd3, 8'h00, 5'b00000}) begin
        errors++;
        $display("FAIL stall_stable cycle %0d: got dor=%b fields=%h want 1 %h",
                 i, DOR, fields, {4'h0, 2'd1, 2'd3, 8'h00, 5'b00000});
      end
      @(negedge clk);
    end
    exec_ack();
    if (!(ok1 && ok2)) bad++;
    for (int n = 1; n < 256; n++) begin
      issue_byte(8'h00, ok1);
      wait_dor(ok2);
      if (!(ok1 && ok2)) bad++;
      exec_ack();
      if (n == 254) begin
        checks++;
        if (insn_count !== 8'd255) begin
          errors++;
          $display("FAIL count_255: got %0d want 255", insn_count);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_handshake: got %0d timeouts want 0", bad);
    end
    checks++;
    if (insn_count !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap: got %0d want 0", insn_count);
    end
  endtask

  initial begin
    reset = 1'b0;
    DIR = 1'b0;
    data_in = 8'h00;
    ack_from_next = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_ack_while_idle();
    test_two_byte();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_wrap_and_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Downstream neighbour of the instruction fetch stage. Takes fetched bytes over the fetch stage's DOR/ack handshake. Decodes the 8-bit opcode into register, ALU and control fields, and collects a second immediate byte for opcodes that need one. Presents one decoded instruction at a time to the execute stage over the same DOR/ack handshake, and counts retired decodes.

## Interface
- COUNT_WIDTH, 8: width of insn_count.
- HALT_STICKY, 1: 1 = after emitting HALT, accept nothing until reset; 0 = HALT decodes like any single-byte opcode.
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset).
- DIR  in  1  upstream byte valid (driven by fetch DOR).
- data_in  in  8  upstream byte.
- ack_prev  out  1  one-cycle accept pulse to upstream (feeds fetch ack_from_next).
- DOR  out  1  decoded instruction valid to execute.
- ack_from_next  in  1  execute accepted the instruction.
- alu_op  out  4  opcode[7:4].
- rd  out  2  opcode[3:2].
- rs  out  2  opcode[1:0].
- imm  out  8  immediate byte; 0 when has_imm=0.
- has_imm, is_mem, is_branch, illegal, halt  out  1 each  decode flags.
- insn_count  out  COUNT_WIDTH  count of instructions accepted by execute.

## Operation
- Opcode classes (alu_op):
  - 0 NOP.
  - 1 LDI: imm.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 MOV.
  - 8 LD: imm, mem.
  - 9 ST: imm, mem.
  - A JMP: imm, branch.
  - B JZ: imm, branch.
  - C–E illegal.
  - F HALT.
- has_imm=1 exactly for classes 1, 8–B.
- Illegal opcodes are emitted with illegal=1, has_imm=0, and never fetch an immediate.
- States:
  - IDLE: if DIR, latch data_in as opcode, pulse ack_prev, go to ACK_OP.
  - ACK_OP: DIR ignored. If has_imm, go to WAIT_IMM; else go to OUT.
  - WAIT_IMM: if DIR, latch data_in as imm, pulse ack_prev, go to ACK_IMM.
  - ACK_IMM: DIR ignored. Go to OUT.
  - OUT: DOR=1, all decode outputs stable. On ack_from_next: DOR←0 and insn_count+1. Then go to HALTED if (halt & HALT_STICKY), else IDLE.
  - HALTED: DIR never acked, DOR=0; exit only by reset.
- Decode outputs are registered from the latched opcode/imm and stay constant from the first DOR cycle until the ack is sampled.
- insn_count wraps from all-ones to 0 and is not saturating.
- Reset (reset=0 at a posedge) applies in any state, including mid-immediate or while DOR=1. All outputs go to 0, state goes to IDLE, and the partially collected instruction is discarded with no count.

## Timing
- ack_prev is high for exactly one cycle per accepted byte.
- Ignore cycle: upstream drops DIR one cycle after seeing ack. The cycle after the ack pulse (ACK_OP/ACK_IMM) ignores DIR, so no byte is accepted twice.
- Single-byte latency: DIR sampled at edge N → ack_prev high N+1 → DOR high N+2.
- Two-byte latency: immediate DIR sampled at edge M → ack_prev high M+1 → DOR high M+2.
- DOR holds until ack_from_next is sampled high; DOR is low in the following cycle.
- Minimum 1 cycle of DOR=0 between instructions.
- ack_from_next while DOR=0 is ignored.
- DIR held high in OUT or HALTED is not acked.
- Reset values: ack_prev=0, DOR=0, alu_op=0, rd=0, rs=0, imm=0, all flags=0, insn_count=0.

## Test plan
- Reset: hold reset=0 for 2 cycles with DIR=1 → every output 0, no ack_prev.
- Single-byte: send 0x2B (ADD rd=2 rs=3), execute acks after 3 cycles → ack_prev one pulse; DOR from N+2 with alu_op=2, rd=2, rs=3, has_imm=0; insn_count=1 after the ack.
- Two-byte: send 0x84 then 0x5A, DIR held one extra cycle after each ack → exactly two ack pulses; output alu_op=8, rd=1, is_mem=1, imm=0x5A.
- Illegal and halt:
  - Send 0xC0 → illegal=1, no immediate fetch.
  - Send 0xF0, then 0x10 → halt=1 emitted; 0x10 never acked while HALTED.
  - Reset, then 0x10 0x07 → LDI imm=0x07 decoded.
- Reset mid-operation: send 0xA0, assert reset before the immediate byte → state IDLE, insn_count unchanged at 0; the next byte is treated as an opcode.
- Counter wrap: COUNT_WIDTH=8, 256 NOPs acked → insn_count returns to 0; a stalled ack (DOR held 10 cycles) leaves outputs stable throughout.
